img_frame_arbiter: RTL and testbench
====================================

# img_frame_arbiter

Frame-level arbiter and sequencer between the two slave input ports (slv0, slv1) and the single shared pixel-processing core of the image processing accelerator. Grants one slave for a whole BMP frame and forwards its 32-bit words to the core with the frame's mode and proc_val. Parses the little-endian BMP header on the fly to tag header words as pass-through and to mark the last word of the frame. Grants are round-robin at frame granularity.

## Interface
- DATA_WIDTH, 32, bus width; only 32 is supported.
- COLOR_W, 8, width of proc_val, equal to `COLOR_SIZE`.
- TIMEOUT_CYCLES, 256, idle-cycle limit; used only with IMG_ARB_TIMEOUT_EN.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- slvN_mode  in  2  frame mode (N = 0, 1); sampled at grant.
- slvN_data_valid  in  1  slave word valid.
- slvN_proc_val  in  COLOR_W  frame processing value; sampled at grant.
- slvN_data  in  DATA_WIDTH  frame word; byte k of the file sits in bits [8k%32 +: 8].
- slvN_ready  out  1  word accepted when valid && ready.
- core_valid / core_ready  out / in  1  output handshake.
- core_data  out  DATA_WIDTH  forwarded word.
- core_mode  out  2  latched mode.
- core_proc_val  out  COLOR_W  latched proc_val.
- core_hdr  out  1  word is header (pass-through).
- core_last  out  1  last word of frame.
- grant  out  2  one-hot owner; 0 when idle.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_err  out  1  sticky error for the current frame; cleared at the next grant.

## Operation
- The FSM has four states: IDLE, XFER, DRAIN, DONE.
- IDLE: if any slvN_data_valid is high, set grant by round-robin, latch that slave's mode and proc_val, clear the byte count and frame_err, then go to XFER.
  - The round-robin pointer resets to "last=slv1", so slv0 wins the first tie.
- XFER: slvN_ready = grant[N] && (!core_valid || core_ready). The ungranted slave's ready is always 0.
- Each accepted word advances byte_idx by 4.
  - Word at byte_idx 0 latches file_size[15:0] from bytes 2–3.
  - Word at byte_idx 4 latches file_size[31:16] from bytes 4–5.
  - Word at byte_idx 8 latches data_start[15:0] from bytes 10–11.
  - Word at byte_idx 12 latches data_start[31:16] from bytes 12–13.
- core_hdr = 1 for every word while byte_idx < 16. After that, core_hdr = (byte_idx < data_start). A word straddling the data_start boundary counts as header.
- core_last = 1 when byte_idx + 4 >= file_size, evaluated only for byte_idx >= 12. On accepting the last word, go to DRAIN.
- If file_size < 16 (known after the word at byte_idx 4): set frame_err and force core_last on the word at byte_idx 12.
- DRAIN: wait until the output register is empty, then go to DONE.
- DONE: pulse frame_done, set grant = 0, update the round-robin pointer, return to IDLE.
- Arithmetic: byte_idx and file_size are 32-bit unsigned. Compare byte_idx + 4 in 33 bits, so there is no wrap.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pointer = slv1.
- Reset asserted mid-frame aborts immediately. The partial frame is discarded and no frame_done is issued.
- Grant appears 1 cycle after valid is seen in IDLE. The first slvN_ready can assert on the cycle grant becomes high.
- Latency: a word accepted at edge k appears on core_data after edge k (1-cycle register).
- Full throughput: one word per cycle while core_ready = 1.
- core_valid holds and all core_* outputs stay stable until core_ready.
- Frame turnaround: from the last-word accept to the next grant is ≥ 3 cycles (DRAIN ≥ 1, DONE 1, IDLE 1).
- A slave dropping valid mid-frame stalls the frame; the grant is held.
- Mode and proc_val changes on the slave port mid-frame are ignored.

## Configuration
- IMG_ARB_TIMEOUT_EN defined: in XFER, a counter counts cycles with the granted slave's valid = 0. It resets on every accept.
  - Reaching TIMEOUT_CYCLES sets frame_err.
  - The output register still drains; no core_last is emitted.
  - The FSM then goes DRAIN → DONE with frame_done pulsed.
- IMG_ARB_TIMEOUT_EN undefined: there is no counter and the stall lasts indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Package img_acc_pkg holds:
  - arb_state_e enum;
  - BMP constants: FSIZE_OFS = 2, DSTART_OFS = 10, MIN_HDR_BYTES = 16;
  - COLOR_W default.
- Sub-module img_arb_out_reg: the 1-entry valid/ready output register carrying data, hdr and last. Its ready_in term feeds slvN_ready.

## Test plan
- slv0 frame with file_size = 70 and data_start = 54:
  - 18 words out;
  - core_hdr = 1 on words 0–13, 0 on words 14–17;
  - core_last on word 17 only;
  - one frame_done pulse.
- Both slaves valid after reset, two frames each → grant order slv0, slv1, slv0, slv1. The ungranted ready stays 0 throughout.
- core_ready toggling 1/0 every cycle during a frame → no word lost or duplicated, core_data stable while stalled, 2 cycles per word.
- Header with file_size = 10 → frame_err = 1, core_last on word 3, frame_done, next grant clears frame_err.
- Reset pulsed at word 5 of 18 → all outputs 0 asynchronously. The next frame starts at byte_idx 0 with grant = slv0.
- With IMG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the slave stops after word 4 → frame_err set 8 cycles later, frame_done pulses, grant returns to 0.

Source files
------------

// File: rtl/img_acc_pkg.sv
// Shared types and BMP header constants for the image accelerator frame arbiter.
package img_acc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_XFER  = 2'd1,
      ARB_DRAIN = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_e;

   // Byte offsets inside the little-endian BMP file header.
   localparam int unsigned FSIZE_OFS     = 2;
   localparam int unsigned DSTART_OFS    = 10;
   localparam int unsigned MIN_HDR_BYTES = 16;

   localparam int COLOR_SIZE = 8;

endpackage

// File: rtl/img_arb_out_reg.sv
// One-entry valid/ready output register carrying a frame word plus its header/last tags.
module img_arb_out_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  hdr_i,
   input  logic                  last_i,
   output logic                  ready_in_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  hdr_o,
   output logic                  last_o,
   input  logic                  ready_i
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  hdr_q;
   logic                  last_q;

   // Room exists when empty or when the held word leaves this cycle.
   assign ready_in_o = !valid_q || ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         hdr_q   <= 1'b0;
         last_q  <= 1'b0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         hdr_q   <= hdr_i;
         last_q  <= last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign hdr_o   = hdr_q;
   assign last_o  = last_q;

endmodule

// File: rtl/img_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding BMP words from two slaves to one pixel core.
// Define IMG_ARB_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle cycles from the granted slave.
module img_frame_arbiter
   import img_acc_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int COLOR_W        = COLOR_SIZE,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            slv0_mode,
   input  logic                  slv0_data_valid,
   input  logic [COLOR_W-1:0]    slv0_proc_val,
   input  logic [DATA_WIDTH-1:0] slv0_data,
   output logic                  slv0_ready,
   input  logic [1:0]            slv1_mode,
   input  logic                  slv1_data_valid,
   input  logic [COLOR_W-1:0]    slv1_proc_val,
   input  logic [DATA_WIDTH-1:0] slv1_data,
   output logic                  slv1_ready,
   output logic                  core_valid,
   input  logic                  core_ready,
   output logic [DATA_WIDTH-1:0] core_data,
   output logic [1:0]            core_mode,
   output logic [COLOR_W-1:0]    core_proc_val,
   output logic                  core_hdr,
   output logic                  core_last,
   output logic [1:0]            grant,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam logic [31:0] FS_LO_IDX = 32'((FSIZE_OFS / 4) * 4);
   localparam logic [31:0] FS_HI_IDX = 32'(((FSIZE_OFS + 2) / 4) * 4);
   localparam logic [31:0] DS_LO_IDX = 32'((DSTART_OFS / 4) * 4);
   localparam logic [31:0] DS_HI_IDX = 32'(((DSTART_OFS + 2) / 4) * 4);
   localparam int FS_LO_BIT = (FSIZE_OFS % 4) * 8;
   localparam int FS_HI_BIT = ((FSIZE_OFS + 2) % 4) * 8;
   localparam int DS_LO_BIT = (DSTART_OFS % 4) * 8;
   localparam int DS_HI_BIT = ((DSTART_OFS + 2) % 4) * 8;

   arb_state_e           state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic                 rr_last_q, rr_last_d;
   logic [1:0]           mode_q, mode_d;
   logic [COLOR_W-1:0]   pval_q, pval_d;
   logic [31:0]          byte_idx_q, byte_idx_d;
   logic [31:0]          fsize_q, fsize_d;
   logic [31:0]          dstart_q, dstart_d;
   logic                 err_q, err_d;

   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  out_rdy;
   logic                  in_xfer;
   logic                  accept;
   logic                  hdr_w;
   logic                  last_w;
   logic                  to_hit;

   assign sel_valid = grant_q[0] ? slv0_data_valid : (grant_q[1] ? slv1_data_valid : 1'b0);
   assign sel_data  = grant_q[0] ? slv0_data : slv1_data;
   assign in_xfer   = (state_q == ARB_XFER);
   assign accept    = in_xfer && sel_valid && out_rdy;

   assign slv0_ready = in_xfer && grant_q[0] && out_rdy;
   assign slv1_ready = in_xfer && grant_q[1] && out_rdy;

   // A word straddling data_start still counts as header; runt files end at byte 12.
   assign hdr_w  = (byte_idx_q < MIN_HDR_BYTES) || (byte_idx_q < dstart_q);
   assign last_w = (byte_idx_q >= 32'd12) &&
                   (({1'b0, byte_idx_q} + 33'd4 >= {1'b0, fsize_q}) ||
                    ((fsize_q < MIN_HDR_BYTES) && (byte_idx_q == 32'd12)));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_last_d  = rr_last_q;
      mode_d     = mode_q;
      pval_d     = pval_q;
      byte_idx_d = byte_idx_q;
      fsize_d    = fsize_q;
      dstart_d   = dstart_q;
      err_d      = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (slv0_data_valid || slv1_data_valid) begin
               grant_d    = (slv0_data_valid && (!slv1_data_valid || rr_last_q)) ? 2'b01 : 2'b10;
               mode_d     = grant_d[0] ? slv0_mode : slv1_mode;
               pval_d     = grant_d[0] ? slv0_proc_val : slv1_proc_val;
               byte_idx_d = '0;
               fsize_d    = '0;
               dstart_d   = '0;
               err_d      = 1'b0;
               state_d    = ARB_XFER;
            end
         end
         ARB_XFER: begin
            if (accept) begin
               byte_idx_d = byte_idx_q + 32'd4;
               case (byte_idx_q)
                  FS_LO_IDX: fsize_d[15:0]  = sel_data[FS_LO_BIT +: 16];
                  FS_HI_IDX: begin
                     fsize_d[31:16] = sel_data[FS_HI_BIT +: 16];
                     if ({sel_data[FS_HI_BIT +: 16], fsize_q[15:0]} < MIN_HDR_BYTES) err_d = 1'b1;
                  end
                  DS_LO_IDX: dstart_d[15:0]  = sel_data[DS_LO_BIT +: 16];
                  DS_HI_IDX: dstart_d[31:16] = sel_data[DS_HI_BIT +: 16];
                  default: ;
               endcase
               if (last_w) state_d = ARB_DRAIN;
            end else if (to_hit) begin
               err_d   = 1'b1;
               state_d = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (!core_valid) state_d = ARB_DONE;
         end
         ARB_DONE: begin
            rr_last_d = grant_q[1];
            grant_d   = 2'b00;
            state_d   = ARB_IDLE;
         end
      endcase
   end

`ifdef IMG_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q;
      to_hit   = 1'b0;
      if (!in_xfer || accept) begin
         to_cnt_d = '0;
      end else if (!sel_valid) begin
         to_hit   = (to_cnt_q == TO_LAST);
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_cnt_q <= '0;
      else        to_cnt_q <= to_cnt_d;
   end
`else
   logic unused_timeout;
   assign to_hit         = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_last_q  <= 1'b1;
         mode_q     <= '0;
         pval_q     <= '0;
         byte_idx_q <= '0;
         fsize_q    <= '0;
         dstart_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_last_q  <= rr_last_d;
         mode_q     <= mode_d;
         pval_q     <= pval_d;
         byte_idx_q <= byte_idx_d;
         fsize_q    <= fsize_d;
         dstart_q   <= dstart_d;
         err_q      <= err_d;
      end
   end

   img_arb_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (accept),
      .data_i     (sel_data),
      .hdr_i      (hdr_w),
      .last_i     (last_w),
      .ready_in_o (out_rdy),
      .valid_o    (core_valid),
      .data_o     (core_data),
      .hdr_o      (core_hdr),
      .last_o     (core_last),
      .ready_i    (core_ready)
   );

   assign core_mode     = mode_q;
   assign core_proc_val = pval_q;
   assign grant         = grant_q;
   assign frame_done    = (state_q == ARB_DONE);
   assign frame_err     = err_q;

endmodule

// File: tb/tb_img_frame_arbiter.sv
// Randomized scoreboard bench for img_frame_arbiter; the timeout scenario runs when IMG_ARB_TIMEOUT_EN is defined.
module tb_img_frame_arbiter;

   typedef struct packed { logic [31:0] w; logic first; logic [1:0] m; logic [7:0] pv; } drv_t;
   typedef struct packed { logic [31:0] d; logic hdr; logic last; logic [1:0] m; logic [7:0] pv; } exp_t;
   typedef struct { int fs; int ds; int nsend; logic [1:0] m; logic [7:0] pv; } meta_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  s_mode  [2];
   logic        s_valid [2];
   logic [7:0]  s_pv    [2];
   logic [31:0] s_data  [2];
   logic        slv0_ready, slv1_ready;
   logic        core_valid, core_ready, core_hdr, core_last, frame_done, frame_err;
   logic [31:0] core_data;
   logic [1:0]  core_mode, grant;
   logic [7:0]  core_proc_val;

   always #5 clk = ~clk;

   img_frame_arbiter #(.DATA_WIDTH(32), .COLOR_W(8), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .slv0_mode(s_mode[0]), .slv0_data_valid(s_valid[0]), .slv0_proc_val(s_pv[0]),
      .slv0_data(s_data[0]), .slv0_ready(slv0_ready),
      .slv1_mode(s_mode[1]), .slv1_data_valid(s_valid[1]), .slv1_proc_val(s_pv[1]),
      .slv1_data(s_data[1]), .slv1_ready(slv1_ready),
      .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
      .core_mode(core_mode), .core_proc_val(core_proc_val), .core_hdr(core_hdr),
      .core_last(core_last), .grant(grant), .frame_done(frame_done), .frame_err(frame_err)
   );

   int checks = 0, failures = 0;
   int done_seen = 0, exp_done = 0, popped = 0, epoch = 0, rdy_mode = 0, model_last = 1;
   bit gap_en = 0;
   drv_t dq0[$], dq1[$];
   exp_t sb[$];
   logic [1:0] gq[$];
   logic errq[$];
   logic [31:0] st0[$], st1[$];
   meta_t mq0[$], mq1[$];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
      end
   endtask

   function automatic logic rdy_of(input int s);
      return (s == 0) ? slv0_ready : slv1_ready;
   endfunction

   // Build one BMP frame for slave s; nsend < 0 sends every word of the file.
   task automatic add_frame(input int s, input int fs, input int ds, input int nsend);
      meta_t mt;
      int nw;
      logic [7:0] b[];
      logic [31:0] w;
      nw = (fs < 16) ? 4 : (fs + 3) / 4;
      b = new[nw * 4];
      foreach (b[k]) b[k] = 8'($urandom);
      b[0] = 8'h42;
      b[1] = 8'h4D;
      for (int k = 0; k < 4; k++) begin
         b[2 + k]  = 8'(fs >> (8 * k));
         b[10 + k] = 8'(ds >> (8 * k));
      end
      mt.fs = fs; mt.ds = ds; mt.nsend = (nsend < 0) ? nw : nsend;
      mt.m = 2'($urandom); mt.pv = 8'($urandom);
      for (int i = 0; i < mt.nsend; i++) begin
         w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
         if (s == 0) st0.push_back(w); else st1.push_back(w);
      end
      if (s == 0) mq0.push_back(mt); else mq1.push_back(mt);
   endtask

   // Reference model: frame-level round robin, header/last rules from the BMP fields.
   task automatic launch();
      int pick, nw;
      meta_t mt;
      exp_t e;
      drv_t d;
      logic [31:0] w;
      while (mq0.size() + mq1.size() > 0) begin
         if (mq0.size() > 0 && mq1.size() > 0) pick = (model_last == 1) ? 0 : 1;
         else pick = (mq0.size() > 0) ? 0 : 1;
         model_last = pick;
         mt = (pick == 0) ? mq0.pop_front() : mq1.pop_front();
         nw = (mt.fs < 16) ? 4 : (mt.fs + 3) / 4;
         gq.push_back((pick == 0) ? 2'b01 : 2'b10);
         errq.push_back((mt.fs < 16) || (mt.nsend < nw));
         exp_done++;
         for (int i = 0; i < mt.nsend; i++) begin
            w = (pick == 0) ? st0.pop_front() : st1.pop_front();
            e.d = w; e.hdr = (4*i < 16) || (4*i < mt.ds); e.last = (i == nw - 1);
            e.m = mt.m; e.pv = mt.pv;
            sb.push_back(e);
            d.w = w; d.first = (i == 0); d.m = mt.m; d.pv = mt.pv;
            if (pick == 0) dq0.push_back(d); else dq1.push_back(d);
         end
      end
   endtask

   task automatic drive(input int s);
      drv_t d;
      int ep;
      bit got;
      forever begin
         got = 0;
         if (s == 0 && dq0.size() > 0) begin d = dq0.pop_front(); got = 1; end
         else if (s == 1 && dq1.size() > 0) begin d = dq1.pop_front(); got = 1; end
         if (!got) begin
            s_valid[s] = 1'b0;
            @(posedge clk); #1;
         end else begin
            ep = epoch;
            if (!d.first && gap_en) begin
               repeat ($urandom_range(0, 2)) begin
                  s_valid[s] = 1'b0; s_data[s] = $urandom;
                  @(posedge clk); #1;
               end
            end
            if (d.first) begin s_mode[s] = d.m; s_pv[s] = d.pv; end
            s_data[s] = d.w; s_valid[s] = 1'b1;
            forever begin
               @(negedge clk);
               if (ep != epoch) break;
               if (rdy_of(s)) begin @(posedge clk); #1; break; end
            end
            // Scribble on mode/proc_val mid-frame; the arbiter must keep the latched values.
            if (d.first) begin s_mode[s] = 2'($urandom); s_pv[s] = 8'($urandom); end
         end
      end
   endtask

   initial begin
      core_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: core_ready = 1'b1;
            1: core_ready = ~core_ready;
            default: core_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   logic        prev_stall = 1'b0;
   logic [33:0] prev_word = '0;
   logic [1:0]  prev_grant = '0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_grant = 2'b00;
      end else begin
         if (!grant[0]) check("slv0_ready_ungranted", slv0_ready, 0);
         if (!grant[1]) check("slv1_ready_ungranted", slv1_ready, 0);
         if (prev_stall) check("stall_hold", {core_valid, core_hdr, core_last, core_data}, {1'b1, prev_word});
         if (grant != 2'b00 && prev_grant == 2'b00) begin
            if (gq.size() == 0) check("grant_unexpected", grant, 0);
            else check("grant_order", grant, gq.pop_front());
            check("err_cleared_at_grant", frame_err, 0);
         end
         if (frame_done) begin
            done_seen++;
            if (errq.size() == 0) check("done_unexpected", frame_done, 0);
            else check("frame_err", frame_err, errq.pop_front());
            $display("frame %0d done grant=%b err=%b t=%0t", done_seen, grant, frame_err, $time);
         end
         if (core_valid && core_ready) begin
            if (sb.size() == 0) check("word_unexpected", core_valid, 0);
            else begin
               e = sb.pop_front();
               popped++;
               check("core_data", core_data, e.d);
               check("core_hdr", core_hdr, e.hdr);
               check("core_last", core_last, e.last);
               check("core_mode_pval", {core_mode, core_proc_val}, {e.m, e.pv});
            end
         end
         prev_stall = core_valid && !core_ready;
         prev_word  = {core_hdr, core_last, core_data};
         prev_grant = grant;
      end
   end

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      while ((sb.size() != 0 || done_seen != exp_done) && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (8) @(posedge clk);
      #2;
      check({nm, "_completed"}, (n < budget), 1);
      check({nm, "_done_count"}, done_seen, exp_done);
      check({nm, "_idle_grant"}, grant, 0);
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, slv0_ready, slv1_ready, core_valid, core_data, core_mode, core_proc_val,
              core_hdr, core_last, grant, frame_done, frame_err};
   endfunction

   initial begin
      for (int s = 0; s < 2; s++) begin
         s_mode[s] = '0; s_valid[s] = 1'b0; s_pv[s] = '0; s_data[s] = '0;
      end
      #3;
      check("reset_outputs", all_outs(), 0);
      #19 rst_n = 1'b1;
      fork
         drive(0);
         drive(1);
      join_none
      @(posedge clk); #2;

      // Both slaves contend for two frames each.
      rdy_mode = 0; gap_en = 0;
      for (int f = 0; f < 2; f++) begin
         add_frame(0, $urandom_range(16, 60), $urandom_range(0, 64), -1);
         add_frame(1, $urandom_range(16, 60), $urandom_range(0, 64), -1);
      end
      launch();
      wait_done("rr_two_each", 2000);

      // Canonical 70-byte frame with 54-byte header.
      add_frame(0, 70, 54, -1);
      launch();
      wait_done("bmp70", 500);

      // Core backpressure toggling every cycle.
      rdy_mode = 1;
      add_frame(0, $urandom_range(16, 80), $urandom_range(0, 90), -1);
      add_frame(1, $urandom_range(16, 80), $urandom_range(0, 90), -1);
      launch();
      wait_done("ready_toggle", 2000);

      // Random backpressure, slave valid gaps, random header fields.
      rdy_mode = 2; gap_en = 1;
      for (int f = 0; f < 5; f++) begin
         int fs;
         fs = $urandom_range(16, 120);
         add_frame((f < 3) ? 0 : 1, fs, $urandom_range(0, fs + 8), -1);
      end
      launch();
      wait_done("random", 4000);

      // Runt file: file_size below the minimum header.
      rdy_mode = 0; gap_en = 0;
      add_frame(0, 10, 54, -1);
      launch();
      wait_done("runt", 500);

      // Reset in the middle of a frame.
      begin
         int base, n;
         base = popped; n = 0;
         add_frame(0, 70, 54, -1);
         launch();
         while (popped < base + 5 && n < 500) begin @(posedge clk); n++; end
         check("rst_reached_word5", (popped >= base + 5), 1);
         @(posedge clk); #2;
         epoch++;
         dq0.delete(); sb.delete(); gq.delete(); errq.delete();
         exp_done--;
         s_valid[0] = 1'b0; s_valid[1] = 1'b0;
         rst_n = 1'b0;
         #1;
         check("async_reset_outputs", all_outs(), 0);
         model_last = 1;
         @(posedge clk); @(posedge clk); #3;
         check("reset_held_outputs", all_outs(), 0);
         rst_n = 1'b1;
         @(posedge clk); #2;
         add_frame(1, 40, 20, -1);
         add_frame(0, 70, 54, -1);
         launch();
         wait_done("after_reset", 1000);
      end

`ifdef IMG_ARB_TIMEOUT_EN
      // Slave goes silent after five words; the idle timeout must close the frame.
      add_frame(0, 70, 54, 5);
      launch();
      wait_done("timeout", 500);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
